// File: rtl/cpu_multi.sv
// Multicycle MIPS-subset core: PC/IR/register file/ALU with a req/ready memory port.
// Stops in HALT on BREAK and in TRAP on illegal encodings or misaligned data addresses.
module cpu_multi #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       pc_dbg
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [2:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir, ir_nxt;
  logic [31:0] a, a_nxt;
  logic [31:0] b, b_nxt;
  logic [31:0] alu_out, alu_nxt;
  logic [31:0] mdr, mdr_nxt;
  logic [31:0] rf [32];

  logic              req_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic              halted_nxt;
  logic              illegal_nxt;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] rf_rs, rf_rt;
  logic [31:0] ea;
  logic [31:0] r_result;
  logic        legal;
  logic        handshake;

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
  assign rf_rs     = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rf_rt     = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign ea        = a + imm_sext;
  assign handshake = mem_req & mem_ready;
  assign pc_dbg    = pc;

  // Encoding legality, checked in DECODE
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_BREAK: legal = 1'b1;
          default:                                         legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  // R-type ALU
  always_comb begin
    r_result = 32'd0;
    case (funct)
      FN_ADD:  r_result = a + b;
      FN_SUB:  r_result = a - b;
      FN_AND:  r_result = a & b;
      FN_OR:   r_result = a | b;
      FN_SLT:  r_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r_result = 32'd0;
    endcase
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    a_nxt     = a;
    b_nxt     = b;
    alu_nxt   = alu_out;
    mdr_nxt   = mdr;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    rf_we     = 1'b0;
    rf_waddr  = (opcode == OP_R) ? rd : rt;
    rf_wdata  = (opcode == OP_LW) ? mdr : alu_out;

    unique case (state)
      S_FETCH: begin
        if (handshake) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + 32'd4;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        a_nxt     = rf_rs;
        b_nxt     = rf_rt;
        alu_nxt   = pc + (imm_sext << 2);
        state_nxt = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            if (funct == FN_BREAK) begin
              state_nxt = S_HALT;
            end else begin
              alu_nxt   = r_result;
              state_nxt = S_WB;
            end
          end
          OP_ADDI: begin
            alu_nxt   = ea;
            state_nxt = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_nxt = ea;
            if (ea[1:0] != 2'b00) begin
              state_nxt = S_TRAP;
            end else begin
              we_nxt    = (opcode == OP_SW);
              addr_nxt  = ADDR_W'(ea);
              wdata_nxt = b;
              state_nxt = S_MEM;
            end
          end
          OP_BEQ: begin
            if (a == b) pc_nxt = alu_out;
            state_nxt = S_FETCH;
          end
          OP_J: begin
            pc_nxt    = {pc[31:28], ir[25:0], 2'b00};
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (handshake) begin
          if (opcode == OP_LW) begin
            mdr_nxt   = mem_rdata;
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we     = (rf_waddr != 5'd0);
        state_nxt = S_FETCH;
      end
      S_HALT, S_TRAP: state_nxt = state;
      default:        state_nxt = S_TRAP;
    endcase

    // Bus values for the cycle that follows; fetch always reads at the updated PC
    req_nxt = (state_nxt == S_FETCH) || (state_nxt == S_MEM);
    if (state_nxt == S_FETCH) begin
      we_nxt   = 1'b0;
      addr_nxt = ADDR_W'(pc_nxt);
    end
    halted_nxt  = (state_nxt == S_HALT) || (state_nxt == S_TRAP);
    illegal_nxt = (state_nxt == S_TRAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      alu_out   <= 32'd0;
      mdr       <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      alu_out   <= alu_nxt;
      mdr       <= mdr_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      halted    <= halted_nxt;
      illegal   <= illegal_nxt;
    end
  end

  // Register file; $0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_multi.sv
// Directed-program bench for cpu_multi with a wait-state memory model and an 8-bit-address instance.
module tb_cpu_multi;

  localparam int OP_R = 'h00, OP_J = 'h02, OP_BEQ = 'h04, OP_ADDI = 'h08, OP_LW = 'h23, OP_SW = 'h2B;
  localparam int FN_BREAK = 'h0D, FN_ADD = 'h20, FN_SUB = 'h22, FN_SLT = 'h2A;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic        req8, we8, halted8, illegal8;
  logic [7:0]  addr8;
  logic [31:0] wdata8, pc8;
  logic [7:0]  q8 [$];

  int n_vec = 0;
  int n_err = 0;
  int prog_sel = 1;
  int wait_cycles = 0;

  logic [31:0] mem [256];
  logic [31:0] acc_q [$];
  int          acc_len, req_cycles, unstable, sw_len, lw_len;
  logic [31:0] hold_addr, hold_wdata, sw_wdata;
  logic        hold_we;

  always #5 clk = ~clk;

  cpu_multi dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .illegal(illegal), .pc_dbg(pc_dbg)
  );

  cpu_multi #(.RESET_PC(32'h0000_00FC), .ADDR_W(8)) dut8 (
    .clk(clk), .reset(reset),
    .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
    .mem_rdata(32'h2000_0000), .mem_ready(1'b1),
    .halted(halted8), .illegal(illegal8), .pc_dbg(pc8)
  );

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic logic [31:0] prog_word(input int sel, input int idx);
    logic [31:0] brk;
    logic [31:0] w;
    brk = enc_r(0, 0, 0, FN_BREAK);
    w = 32'd0;
    case (sel)
      1: case (idx)
           0: w = enc_i(OP_ADDI, 0, 1, 5);
           1: w = enc_i(OP_ADDI, 0, 2, -3);
           2: w = enc_r(1, 2, 3, FN_ADD);
           3: w = enc_r(2, 1, 4, FN_SUB);
           4: w = enc_r(2, 1, 5, FN_SLT);
           5: w = brk;
           default: w = 32'd0;
         endcase
      2: case (idx)
           0: w = enc_i(OP_ADDI, 0, 1, 5);
           1: w = enc_i(OP_SW, 0, 1, 'h100);
           2: w = enc_i(OP_LW, 0, 6, 'h100);
           3: w = brk;
           default: w = 32'd0;
         endcase
      3: case (idx)
           0: w = enc_i(OP_ADDI, 0, 1, 7);
           1: w = enc_i(OP_ADDI, 0, 2, 7);
           2: w = enc_i(OP_BEQ, 1, 2, 2);
           3, 4, 7, 16: w = brk;
           5: w = enc_i(OP_BEQ, 1, 0, 5);
           6: w = enc_j(OP_J, 'h10);
           default: w = 32'd0;
         endcase
      4: case (idx)
           0: w = enc_i(OP_ADDI, 0, 1, 1);
           1: w = enc_i('h3F, 0, 2, 9);
           2: w = brk;
           default: w = 32'd0;
         endcase
      5: case (idx)
           0: w = enc_i(OP_LW, 0, 8, 'h100);
           1: w = brk;
           64: w = 32'h0000_1234;
           default: w = 32'd0;
         endcase
      6: case (idx)
           0: w = enc_i(OP_ADDI, 0, 0, 7);
           1: w = enc_r(0, 0, 1, FN_ADD);
           2: w = brk;
           default: w = 32'd0;
         endcase
      7: case (idx)
           0: w = enc_i(OP_ADDI, 0, 1, 6);
           1: w = enc_r(1, 1, 3, 'h01);
           2: w = brk;
           default: w = 32'd0;
         endcase
      8: case (idx)
           0: w = enc_i(OP_ADDI, 0, 1, 'h100);
           1: w = enc_i(OP_LW, 1, 7, 2);
           2: w = brk;
           default: w = 32'd0;
         endcase
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Memory model: decides ready/rdata on the falling edge, reloads the program while in reset
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] = prog_word(prog_sel, i);
      acc_q.delete();
      acc_len = 0; req_cycles = 0; unstable = 0; sw_len = 0; lw_len = 0; sw_wdata = 32'd0;
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
    end else if (mem_req) begin
      req_cycles++;
      if (acc_len > 0 && (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata))
        unstable++;
      hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
      acc_len++;
      if (acc_len > wait_cycles) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        acc_q.push_back(mem_addr);
        if (mem_addr == 32'h100) begin
          if (mem_we) begin
            sw_len = acc_len;
            sw_wdata = mem_wdata;
          end else begin
            lw_len = acc_len;
          end
        end
        acc_len = 0;
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      mem_ready = 1'b0;
      acc_len = 0;
    end
  end

  always @(negedge clk) begin
    if (reset && req8 && q8.size() < 4) q8.push_back(addr8);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int sel, input int waits);
    @(negedge clk);
    prog_sel = sel;
    wait_cycles = waits;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Cycles counted from the first fetch cycle to the first cycle showing halted
  task automatic run_until_halt(output int cyc);
    @(negedge clk);
    check("req_first_cycle", 32'(mem_req), 32'd1);
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("halt_timeout", 32'(cyc < 3000), 32'd1);
  endtask

  initial begin
    int cyc;
    int n;

    // Reset state
    prog_sel = 1;
    wait_cycles = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pc", pc_dbg, 32'h0);
    reset = 1'b1;

    // Arithmetic program, zero-wait
    run_until_halt(cyc);
    check("arith_r3", dut.rf[3], 32'd2);
    check("arith_r4", dut.rf[4], 32'hFFFF_FFF8);
    check("arith_r5", dut.rf[5], 32'd1);
    check("arith_halted", 32'(halted), 32'd1);
    check("arith_illegal", 32'(illegal), 32'd0);
    check("arith_cycles", 32'(cyc), 32'd23);

    // Store then load with two wait cycles per access
    do_reset(2, 2);
    run_until_halt(cyc);
    check("ldst_r6", dut.rf[6], 32'd5);
    check("ldst_memword", mem[64], 32'd5);
    check("ldst_sw_wdata", sw_wdata, 32'd5);
    check("ldst_stable", 32'(unstable), 32'd0);
    check("ldst_sw_len", 32'(sw_len), 32'd3);
    check("ldst_lw_len", 32'(lw_len), 32'd3);

    // Branches and jump: fetch address sequence
    do_reset(3, 0);
    run_until_halt(cyc);
    check("br_nacc", 32'(acc_q.size()), 32'd6);
    check("br_taken_pc", acc_q[3], 32'h14);
    check("br_ntaken_pc", acc_q[4], 32'h18);
    check("j_target", acc_q[5], 32'h40);
    check("j_final_pc", pc_dbg, 32'h44);
    check("br_illegal", 32'(illegal), 32'd0);

    // Illegal opcode
    do_reset(4, 0);
    run_until_halt(cyc);
    check("ilop_illegal", 32'(illegal), 32'd1);
    check("ilop_halted", 32'(halted), 32'd1);
    check("ilop_r2", dut.rf[2], 32'd0);
    check("ilop_r1", dut.rf[1], 32'd1);
    check("ilop_pc", pc_dbg, 32'h8);

    // Illegal funct
    do_reset(7, 0);
    run_until_halt(cyc);
    check("ilfn_illegal", 32'(illegal), 32'd1);
    check("ilfn_r3", dut.rf[3], 32'd0);

    // Misaligned load
    do_reset(8, 0);
    run_until_halt(cyc);
    check("mis_illegal", 32'(illegal), 32'd1);
    check("mis_req_cycles", 32'(req_cycles), 32'd2);
    check("mis_pc", pc_dbg, 32'h8);
    check("mis_r7", dut.rf[7], 32'd0);
    check("mis_nodata", 32'(acc_q.size()), 32'd2);

    // Reset during a load wait state
    do_reset(5, 5);
    n = 0;
    while (!(mem_req && mem_addr == 32'h100) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rstw_reached", 32'(n < 400), 32'd1);
    #2 reset = 1'b0;
    #1 check("rstw_req_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_refetch_req", 32'(mem_req), 32'd1);
    check("rstw_refetch_addr", mem_addr, 32'h0);
    check("rstw_r8", dut.rf[8], 32'd0);

    // Writes to $0 are discarded
    do_reset(6, 0);
    run_until_halt(cyc);
    check("zero_r0", dut.rf[0], 32'd0);
    check("zero_r1", dut.rf[1], 32'd0);
    check("zero_halted", 32'(halted), 32'd1);

    // 8-bit address instance wraps from 0xFC to 0x00
    check("w8_first", 32'(q8[0]), 32'h0FC);
    check("w8_second", 32'(q8[1]), 32'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_multi.md
# cpu_multi

Parametrised multicycle MIPS-subset core: the successor of the single-instruction add datapath. It integrates PC, IR, 32×32 register file, A/B/ALUOut/MDR registers, ALU and FSM control in one block. The block adds a req/ready memory handshake with wait states, loads/stores, branches, jumps, a halt instruction and illegal/misaligned trapping. It sits between the testbench/top and a single shared instruction+data memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 32, width of mem_addr; carries PC/effective-address bits [ADDR_W-1:0] (byte address)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (SW), 0 = read; valid while mem_req=1
- mem_addr  out  ADDR_W  byte address, word aligned
- mem_wdata  out  32  store data (B register)
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  access completes at the rising edge where mem_req=1 and mem_ready=1
- halted  out  1  core stopped (BREAK or trap)
- illegal  out  1  stop caused by unknown opcode/funct or misaligned address
- pc_dbg  out  32  current PC

## Operation
- Supported: R-type (op 0x00) funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, BREAK 0x0D; ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02. Anything else is illegal.
- Register $0 always reads 0; writes to it are discarded.
- Arithmetic is 32-bit two's complement and wraps; no overflow trap. SLT is signed, result 1/0.
- Immediates are sign-extended. BEQ target = PC+4 + (sext(imm)<<2). J target = {(PC+4)[31:28], imm26, 2'b00}. LW/SW EA = A + sext(imm).
- FSM states:
  - FETCH: req=1, we=0, addr=PC. Holds until ready. At the completing edge: IR<=rdata, PC<=PC+4.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=branch target. Illegal encoding -> TRAP.
  - EXEC: R-type/ADDI: ALUOut<=result. LW/SW: ALUOut<=EA; EA[1:0]≠0 -> TRAP with no memory access. BEQ: PC<=ALUOut if A==B, then FETCH. J: PC<=target, then FETCH. BREAK -> HALT.
  - MEM: LW: req=1, we=0, MDR<=rdata at the ready edge, then WB. SW: req=1, we=1, wdata=B, then FETCH after the ready edge.
  - WB: rf[rd] (R-type) or rf[rt] (ADDI/LW) <= ALUOut/MDR, then FETCH.
  - HALT: halted=1. TRAP: halted=1, illegal=1. Both are terminal until reset.
- During a TRAP caused by misalignment, PC already points past the faulting instruction.

## Timing
- Reset asserted: immediately PC=RESET_PC, all registers 0, mem_req=0, mem_we=0, halted=0, illegal=0, state=FETCH. mem_req rises in the first cycle after reset deasserts.
- Reset asserted mid-handshake aborts the access; mem_req drops asynchronously. No register-file write occurs.
- With zero-wait memory (ready tied 1), CPI is: R-type/ADDI 4, LW 5, SW 4, BEQ 3, J 3, BREAK 3 (then halted).
- Each wait cycle (req=1, ready=0) adds one cycle. mem_addr, mem_we and mem_wdata stay stable while req=1.
- mem_req is 0 in DECODE, EXEC, WB, HALT and TRAP. mem_ready is ignored when req=0.
- halted/illegal assert in the cycle after the edge that enters HALT/TRAP and stay asserted; mem_req stays 0.
- rf writes happen at the WB edge, so a dependent instruction's DECODE always sees the new value; no forwarding is needed.
- ADDR_W<32: upper address bits are dropped silently and wrap modulo 2^ADDR_W.

## Test plan
- Program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1; break" with zero-wait memory -> $3=2, $4=0xFFFFFFF8, $5=1, halted=1, illegal=0. First halted=1 at cycle 4+4+4+4+4+3.
- SW $1 to 0x100, then LW $6 from 0x100, with mem_ready low for 2 cycles on every access -> $6=5. mem_addr/we/wdata are stable during waits. Each access takes 3 cycles.
- BEQ taken (equal regs, imm=2) and not taken; J to 0x40 -> PC after BEQ = PC+12 or PC+4 respectively; PC = 0x40 after J.
- Opcode 0x3F and funct 0x01 -> illegal=1, halted=1, no register write. Separately, LW with EA=0x102 -> TRAP with mem_req never asserted for the load.
- Assert reset during the wait state of a LW -> mem_req=0 immediately; after release, fetch from RESET_PC and destination register still 0.
- Write to $0 (addi $0,$0,7), then add $1,$0,$0 -> $1=0. Run with ADDR_W=8 and RESET_PC=0xFC -> second fetch address wraps to 0x00.
